// File: rtl/sr_pkg.sv
// Shared types and defaults for the debounced set/reset command generator.
// Holds the arbitration FSM state encoding and the set-over-reset priority rule.
package sr_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
    localparam int LOCKOUT_CYCLES_DEFAULT  = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULSE   = 2'd1,
        ST_LOCKOUT = 2'd2
    } sr_state_t;

    typedef struct packed {
        logic s;
        logic r;
        logic conflict;
    } sr_cmd_t;

    // Set wins; a simultaneous reset request is dropped and flagged.
    function automatic sr_cmd_t arbitrate(input logic set_req, input logic clr_req);
        sr_cmd_t cmd;
        cmd.s        = set_req;
        cmd.r        = clr_req & ~set_req;
        cmd.conflict = set_req & clr_req;
        return cmd;
    endfunction

endpackage

// File: rtl/sr_cmd_gen_if.sv
// Button inputs and SR command outputs of sr_cmd_gen, bundled as one port.
// The master side presses buttons; the slave side (the generator) drives the pulses.
interface sr_cmd_gen_if;

    logic set_btn;
    logic clr_btn;
    logic s;
    logic r;
    logic busy;
    logic conflict;

    modport master (
        output set_btn,
        output clr_btn,
        input  s,
        input  r,
        input  busy,
        input  conflict
    );

    modport slave (
        input  set_btn,
        input  clr_btn,
        output s,
        output r,
        output busy,
        output conflict
    );

endinterface

// File: rtl/sr_debounce.sv
// One button channel: 2-flop synchronizer, counting debouncer and registered
// rising-edge detector producing a one-cycle request.
module sr_debounce
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic             rise_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg    <= '0;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
            rise_reg    <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[0], btn};
            level_d_reg <= level_reg;
            rise_reg    <= level_reg & ~level_d_reg;

            // Toggle on the sample that would complete DEBOUNCE_CYCLES differing samples.
            if (sync_reg[1] == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                level_reg <= ~level_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign rise = rise_reg;

endmodule

// File: rtl/sr_cmd_gen.sv
// Turns two bouncing buttons into mutually exclusive single-cycle s/r pulses
// for a downstream SR flip-flop, with set priority and a post-pulse lockout.
module sr_cmd_gen
    import sr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    sr_cmd_gen_if.slave   io
);

    localparam int               LOCK_W    = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

    // Channel 0 is set, channel 1 is clear.
    logic [1:0] btn_vec;
    logic [1:0] rise_vec;

    assign btn_vec = {io.clr_btn, io.set_btn};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            sr_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .rst  (rst),
                .btn  (btn_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    sr_state_t         state_reg;
    logic [LOCK_W-1:0] lock_cnt_reg;
    logic              set_pend_reg;
    logic              clr_pend_reg;
    logic              s_reg;
    logic              r_reg;
    logic              busy_reg;
    logic              conflict_reg;

    logic    set_req;
    logic    clr_req;
    logic    can_start;
    logic    start;
    sr_cmd_t cmd;

    assign set_req   = rise_vec[0] | set_pend_reg;
    assign clr_req   = rise_vec[1] | clr_pend_reg;
    assign can_start = (state_reg == ST_IDLE) ||
                       ((state_reg == ST_LOCKOUT) && (lock_cnt_reg == '0));
    assign start     = can_start & (set_req | clr_req);
    assign cmd       = arbitrate(set_req, clr_req);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            lock_cnt_reg <= '0;
            set_pend_reg <= 1'b0;
            clr_pend_reg <= 1'b0;
            s_reg        <= 1'b0;
            r_reg        <= 1'b0;
            busy_reg     <= 1'b0;
            conflict_reg <= 1'b0;
        end else begin
            s_reg        <= 1'b0;
            r_reg        <= 1'b0;
            conflict_reg <= 1'b0;

            if (start) begin
                // Entering PULSE consumes both pending flags; a losing reset is dropped.
                state_reg    <= ST_PULSE;
                s_reg        <= cmd.s;
                r_reg        <= cmd.r;
                conflict_reg <= cmd.conflict;
                busy_reg     <= 1'b1;
                set_pend_reg <= 1'b0;
                clr_pend_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        busy_reg <= 1'b0;
                    end
                    ST_PULSE: begin
                        state_reg    <= ST_LOCKOUT;
                        lock_cnt_reg <= LOCK_LOAD;
                        set_pend_reg <= set_pend_reg | rise_vec[0];
                        clr_pend_reg <= clr_pend_reg | rise_vec[1];
                    end
                    ST_LOCKOUT: begin
                        if (lock_cnt_reg == '0) begin
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            lock_cnt_reg <= lock_cnt_reg - 1'b1;
                            set_pend_reg <= set_pend_reg | rise_vec[0];
                            clr_pend_reg <= clr_pend_reg | rise_vec[1];
                        end
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign io.s        = s_reg;
    assign io.r        = r_reg;
    assign io.busy     = busy_reg;
    assign io.conflict = conflict_reg;

endmodule
